// File: rtl/roman_char_emitter_pkg.sv
// Package translit_pkg: shared widths, special codes, the code expansion
// entry type, the emitter FSM state type and the expansion ROM function.
//   code2roman(code) -> roman_entry_t {bad, len, c0, c1, c2}
package translit_pkg;

    localparam int CODE_W  = 7;
    localparam int ASCII_W = 8;

    localparam logic [CODE_W-1:0] BUBBLE     = 7'h00;
    localparam logic [CODE_W-1:0] SCHWA_KEEP = 7'h70;
    localparam logic [CODE_W-1:0] SCHWA_DROP = 7'h71;

    // One expansion: len characters taken from c0, c1, c2 in that order.
    // bad marks codes with no table entry (they expand to a single '?').
    typedef struct packed {
        logic               bad;
        logic [1:0]         len;
        logic [ASCII_W-1:0] c0;
        logic [ASCII_W-1:0] c1;
        logic [ASCII_W-1:0] c2;
    } roman_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } emit_state_t;

    function automatic roman_entry_t code2roman(input logic [CODE_W-1:0] code);
        roman_entry_t e;
        e.bad = 1'b0;
        e.len = 2'd1;
        e.c0  = 8'h3F;
        e.c1  = 8'h00;
        e.c2  = 8'h00;
        case (code)
            7'h47:      e.c0 = 8'h6B;                                   // "k"
            7'h5D:      begin e.len = 2'd2; e.c0 = 8'h6B; e.c1 = 8'h68; end // "kh"
            7'h44:      e.c0 = 8'h67;                                   // "g"
            7'h01:      e.c0 = 8'h61;                                   // "a"
            7'h15:      begin e.len = 2'd2; e.c0 = 8'h61; e.c1 = 8'h61; end // "aa"
            SCHWA_KEEP: e.c0 = 8'h61;                                   // "a"
            SCHWA_DROP: begin e.len = 2'd0; e.c0 = 8'h00; end           // nothing
            7'h6B:      begin e.len = 2'd3; e.c0 = 8'h73; e.c1 = 8'h68; e.c2 = 8'h68; end // "shh"
            default:    e.bad = 1'b1;                                   // "?"
        endcase
        return e;
    endfunction

endpackage

// File: rtl/roman_char_emitter_if.sv
// Interface roman_char_emitter_if: code input stream from the mapper and the
// character output stream.
//   code_in/code_valid : mapper side, no back-pressure (valid only)
//   char_out/char_valid/char_ready : character side
// Handshake: a character transfers on a rising edge where char_valid and
// char_ready are both high; once char_valid is raised, char_out is held
// stable and char_valid stays high until that transfer happens.
interface roman_char_emitter_if;
    import translit_pkg::*;

    logic [CODE_W-1:0]  code_in;
    logic               code_valid;
    logic [ASCII_W-1:0] char_out;
    logic               char_valid;
    logic               char_ready;

    modport master (
        output code_in, code_valid, char_ready,
        input  char_out, char_valid
    );

    modport slave (
        input  code_in, code_valid, char_ready,
        output char_out, char_valid
    );

endinterface

// File: rtl/roman_char_emitter_code_fifo.sv
// Module code_fifo: DEPTH x WIDTH synchronous FIFO, no read-through.
//   clock, rst_n : clock, asynchronous active-low reset
//   push, din    : write request and data (accepted when not full, or when
//                  full and a pop happens the same cycle)
//   pop, dout    : read request; dout shows the head entry combinationally
//   full, empty  : occupancy flags
module code_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty when indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = pop && !empty;
    assign do_wr = push && (!full || do_rd);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/roman_char_emitter.sv
// Module roman_char_emitter: buffers English phoneme codes in a FIFO, expands
// each into 0..3 ASCII characters and streams them out one per cycle.
//   clock, rst_n : clock, asynchronous active-low reset
//   bus          : code input stream + character output stream (slave side)
//   overflow     : sticky, a code was dropped because the FIFO was full
//   bad_code     : one-cycle pulse when an unmapped code is loaded
//   char_count   : number of characters handed off, wraps at CNT_W bits
//   state_dbg    : current FSM state
module roman_char_emitter
    import translit_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 rst_n,
    roman_char_emitter_if.slave  bus,
    output logic                 overflow,
    output logic                 bad_code,
    output logic [CNT_W-1:0]     char_count,
    output emit_state_t          state_dbg
);

    emit_state_t        state;
    logic [1:0]         ent_len;
    logic [ASCII_W-1:0] ent_c1;
    logic [ASCII_W-1:0] ent_c2;
    logic [1:0]         idx;
    logic [1:0]         next_idx;
    logic               last_char;
    logic               handshake;
    logic               push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CODE_W-1:0]  fifo_dout;
    roman_entry_t       head_entry;

    assign push       = bus.code_valid && (bus.code_in != BUBBLE);
    assign handshake  = bus.char_valid && bus.char_ready;
    assign next_idx   = idx + 2'd1;
    assign last_char  = (next_idx >= ent_len);
    assign head_entry = code2roman(fifo_dout);
    assign state_dbg  = state;

    // Pop whenever idle, or on the hand-off of the last character of the
    // current entry so the next entry follows with no bubble.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE) begin
                fifo_pop = 1'b1;
            end else if (handshake && last_char) begin
                fifo_pop = 1'b1;
            end
        end
    end

    code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (push),
        .pop   (fifo_pop),
        .din   (bus.code_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ent_len        <= 2'd0;
            ent_c1         <= '0;
            ent_c2         <= '0;
            idx            <= 2'd0;
            bus.char_out   <= '0;
            bus.char_valid <= 1'b0;
            bad_code       <= 1'b0;
            overflow       <= 1'b0;
            char_count     <= '0;
        end else begin
            bad_code <= 1'b0;
            if (handshake) begin
                char_count <= char_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end

            if (fifo_pop) begin
                // Load the head entry; c0 goes straight to the output.
                ent_len  <= head_entry.len;
                ent_c1   <= head_entry.c1;
                ent_c2   <= head_entry.c2;
                idx      <= 2'd0;
                bad_code <= head_entry.bad;
                if (head_entry.len == 2'd0) begin
                    state          <= ST_IDLE;
                    bus.char_valid <= 1'b0;
                end else begin
                    state          <= ST_EMIT;
                    bus.char_valid <= 1'b1;
                    bus.char_out   <= head_entry.c0;
                end
            end else if (state == ST_EMIT && handshake) begin
                if (!last_char) begin
                    idx          <= next_idx;
                    bus.char_out <= (next_idx == 2'd1) ? ent_c1 : ent_c2;
                end else begin
                    state          <= ST_IDLE;
                    bus.char_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_roman_char_emitter.sv
// Testbench for roman_char_emitter: directed scenarios plus random traffic,
// expected characters produced by a string-table model into a queue and
// checked by an independent monitor on the falling clock edge.
module tb_roman_char_emitter;
    import translit_pkg::*;

    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 16;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    roman_char_emitter_if bus();
    logic             overflow;
    logic             bad_code;
    logic [CNT_W-1:0] char_count;
    emit_state_t      state_dbg;

    roman_char_emitter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .bus        (bus),
        .overflow   (overflow),
        .bad_code   (bad_code),
        .char_count (char_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int   checks = 0;
    int   errors = 0;
    logic [8:0] exp_q[$];               // {bad, ascii}
    string roman_tab [logic [6:0]];
    logic [CNT_W-1:0] model_count = '0;
    int   bad_expected = 0;
    int   bad_seen     = 0;
    int   cyc          = 0;
    int   last_hs      = 0;
    int   prev_hs      = 0;
    logic prev_hold    = 1'b0;
    logic [6:0] codes [8] = '{7'h47, 7'h5D, 7'h44, 7'h01, 7'h15, 7'h70, 7'h71, 7'h6B};

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: a code becomes the characters of its table string;
    // bubbles vanish, unknown codes become a flagged '?'.
    function automatic void model_push(input logic [6:0] c);
        string s;
        if (c == 7'h00) return;
        if (!roman_tab.exists(c)) begin
            exp_q.push_back({1'b1, 8'h3F});
            bad_expected++;
        end else begin
            s = roman_tab[c];
            for (int i = 0; i < s.len(); i++) begin
                exp_q.push_back({1'b0, 8'(s[i])});
            end
        end
    endfunction

    function automatic logic [6:0] pick_code();
        int r;
        r = $urandom_range(0, 11);
        if (r < 8)  return codes[r];
        if (r < 11) return 7'($urandom_range(0, 127));
        return 7'h00;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        cyc++;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            check("char_count", 32'(char_count), 32'(model_count));
            if (bad_code) bad_seen++;
            if (bus.char_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_char: got %0h expected no character (t=%0t)",
                             bus.char_out, $time);
                end else begin
                    check("char_out", 32'(bus.char_out), 32'(exp_q[0][7:0]));
                    check("bad_code", 32'(bad_code), prev_hold ? 32'd0 : 32'(exp_q[0][8]));
                    if (bus.char_ready) begin
                        void'(exp_q.pop_front());
                        model_count = model_count + 1'b1;
                        prev_hs = last_hs;
                        last_hs = cyc;
                    end
                end
            end else begin
                check("bad_code_idle", 32'(bad_code), 32'd0);
            end
            prev_hold = bus.char_valid && !bus.char_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_code(input logic [6:0] c, input bit to_model);
        bus.code_in    = c;
        bus.code_valid = 1'b1;
        if (to_model) model_push(c);
        tick();
        bus.code_valid = 1'b0;
        bus.code_in    = 7'h00;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d chars outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [CNT_W-1:0] base;
        logic [7:0]       held;
        logic [6:0]       c;
        int               n;

        roman_tab[7'h47] = "k";
        roman_tab[7'h5D] = "kh";
        roman_tab[7'h44] = "g";
        roman_tab[7'h01] = "a";
        roman_tab[7'h15] = "aa";
        roman_tab[7'h70] = "a";
        roman_tab[7'h71] = "";
        roman_tab[7'h6B] = "shh";

        bus.code_in    = 7'h00;
        bus.code_valid = 1'b0;
        bus.char_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        #2;
        check("rst_char_valid", 32'(bus.char_valid), 32'd0);
        check("rst_char_out",   32'(bus.char_out),   32'd0);
        check("rst_overflow",   32'(overflow),       32'd0);
        check("rst_bad_code",   32'(bad_code),       32'd0);
        check("rst_count",      32'(char_count),     32'd0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (2) tick();

        // Single "kh": code presented after edge N, 'k' after N+2, 'h' after N+3
        base = model_count;
        push_code(7'h5D, 1'b1);
        check("lat_n1_valid", 32'(bus.char_valid), 32'd0);
        tick();
        check("lat_n2_valid", 32'(bus.char_valid), 32'd1);
        check("lat_n2_char",  32'(bus.char_out),   32'h6B);
        tick();
        check("lat_n3_char",  32'(bus.char_out),   32'h68);
        wait_drain(20);
        check("kh_count", 32'(char_count), 32'(base + 16'd2));

        // "k", suppressed schwa, "a": one empty cycle for the len-0 entry
        base = model_count;
        push_code(7'h47, 1'b1);
        push_code(7'h71, 1'b1);
        push_code(7'h01, 1'b1);
        wait_drain(20);
        check("schwa_gap", 32'(last_hs - prev_hs), 32'd2);
        check("schwa_count", 32'(char_count), 32'(base + 16'd2));

        // Unmapped code and bubbles
        push_code(7'h00, 1'b1);
        push_code(7'h3F, 1'b1);
        push_code(7'h00, 1'b1);
        push_code(7'h00, 1'b1);
        push_code(7'h47, 1'b1);
        push_code(7'h00, 1'b1);
        wait_drain(20);
        check("bad_pulses", 32'(bad_seen), 32'(bad_expected));

        // Random traffic with random back-pressure, paced below FIFO capacity
        for (int i = 0; i < 600; i++) begin
            bus.char_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0 && exp_q.size() < 5) begin
                c = pick_code();
                if (c == SCHWA_DROP && exp_q.size() != 0) c = SCHWA_KEEP;
                push_code(c, 1'b1);
            end else begin
                tick();
            end
        end
        bus.char_ready = 1'b1;
        wait_drain(100);
        check("rand_overflow", 32'(overflow), 32'd0);
        check("rand_bad_pulses", 32'(bad_seen), 32'(bad_expected));

        // Overflow: one entry held in EMIT, 9 more codes, the 9th dropped
        bus.char_ready = 1'b0;
        push_code(7'h5D, 1'b1);
        n = 0;
        while (!bus.char_valid && n < 10) begin
            tick();
            n++;
        end
        check("ovf_first_valid", 32'(bus.char_valid), 32'd1);
        held = bus.char_out;
        check("ovf_before", 32'(overflow), 32'd0);
        for (int i = 0; i < 9; i++) begin
            c = (i == 8) ? 7'h44 : codes[$urandom_range(0, 7)];
            push_code(c, i < 8);
        end
        tick();
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_char_stable", 32'(bus.char_out), 32'(held));
        check("ovf_valid_held", 32'(bus.char_valid), 32'd1);
        bus.char_ready = 1'b1;
        wait_drain(100);
        check("ovf_still_set", 32'(overflow), 32'd1);

        // Reset in the middle of a stream
        for (int i = 0; i < 37; i++) begin
            bus.char_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0 && exp_q.size() < 5) begin
                c = pick_code();
                if (c == SCHWA_DROP) c = 7'h6B;
                push_code(c, 1'b1);
            end else begin
                tick();
            end
        end
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",    32'(bus.char_valid), 32'd0);
        check("mid_rst_char",     32'(bus.char_out),   32'd0);
        check("mid_rst_overflow", 32'(overflow),       32'd0);
        check("mid_rst_bad",      32'(bad_code),       32'd0);
        check("mid_rst_count",    32'(char_count),     32'd0);
        exp_q.delete();
        model_count = '0;
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
        bus.char_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_empty", 32'(bus.char_valid), 32'd0);
        end
        check("post_rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // Counter wrap: 21845 x "shh" + "k" = 65536 hand-offs from zero
        for (int i = 0; i < 21845; i++) begin
            push_code(7'h6B, 1'b1);
            tick();
            tick();
        end
        check("wrap_ffff", 32'(char_count + 16'(exp_q.size())), 32'hFFFF);
        push_code(7'h47, 1'b1);
        wait_drain(50);
        check("wrap_zero", 32'(char_count), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
